// File: rtl/reg_file_bank_pkg.sv
// Shared types and constants for the architectural register file and its read muxes.
package reg_file_bank_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int WORD_WIDTH = 32;
  localparam int NUM_REGS   = 16;
  localparam int SP_IDX     = 13;
  localparam int PC_IDX     = 15;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

  typedef enum logic {
    WRITE_DISABLE = 1'b0,
    WRITE_ENABLE  = 1'b1
  } reg_file_write_sig;

endpackage

// File: rtl/reg_file_bank_read_mux.sv
// One read port: PC substitution, write-through bypass from both write ports, then stored value.
module reg_read_mux
  import reg_file_bank_pkg::*;
(
  input  logic              rst_i,
  input  reg_addr_t         rd_addr_i,
  input  word_t             pc_read_val_i,
  input  reg_file_write_sig wb_write_en_i,
  input  reg_addr_t         wb_dest_addr_i,
  input  word_t             wb_data_i,
  input  reg_file_write_sig base_write_en_i,
  input  reg_addr_t         base_dest_addr_i,
  input  word_t             base_data_i,
  input  word_t             stored_i,
  output word_t             rd_data_o
);

  // Writes presented during reset are dropped, so they must not be forwarded either.
  logic wb_hit;
  logic base_hit;

  assign wb_hit   = !rst_i && (wb_write_en_i == WRITE_ENABLE) && (wb_dest_addr_i == rd_addr_i);
  assign base_hit = !rst_i && (base_write_en_i == WRITE_ENABLE) && (base_dest_addr_i == rd_addr_i);

  // NOTE: the default assignment first guarantees every path drives rd_data_o, so no latch is inferred.
  always_comb begin
    rd_data_o = stored_i;
    if (rd_addr_i == reg_addr_t'(PC_IDX)) begin
      rd_data_o = pc_read_val_i;
    end else if (wb_hit) begin
      rd_data_o = wb_data_i;
    end else if (base_hit) begin
      rd_data_o = base_data_i;
    end
  end

endmodule

// File: rtl/reg_file_bank.sv
// Architectural register file: r0..r14 stored, PC synthesised from the fetch value,
// two write ports (write-back and base update), three bypassed read ports.
module reg_file_bank
  import reg_file_bank_pkg::*;
#(
  parameter word_t SP_RESET = 32'h0000_1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  reg_file_write_sig wb_write_en_i,
  input  reg_addr_t         wb_dest_addr_i,
  input  word_t             wb_data_i,
  input  reg_file_write_sig base_write_en_i,
  input  reg_addr_t         base_dest_addr_i,
  input  word_t             base_data_i,
  input  word_t             pc_read_val_i,
  input  reg_addr_t         rd_addr_a_i,
  input  reg_addr_t         rd_addr_b_i,
  input  reg_addr_t         rd_addr_c_i,
  output word_t             rd_data_a_o,
  output word_t             rd_data_b_o,
  output word_t             rd_data_c_o,
  output logic [31:0]       write_count_o
);

  localparam int NUM_STORED = NUM_REGS - 1;

  word_t       regs_q [NUM_STORED];
  logic [31:0] write_count_q;
  logic        wb_commit;
  logic        base_commit;

  // On a same-address dual write the write-back port wins and base is discarded.
  assign wb_commit   = (wb_write_en_i == WRITE_ENABLE) && (wb_dest_addr_i != reg_addr_t'(PC_IDX));
  assign base_commit = (base_write_en_i == WRITE_ENABLE)
                    && (base_dest_addr_i != reg_addr_t'(PC_IDX))
                    && !(wb_commit && (wb_dest_addr_i == base_dest_addr_i));

  // NOTE: the whole array is reset because SP needs a non-zero value and the file is small;
  // large memories would normally be left unreset. Non-blocking assignments keep every flop
  // sampling pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_STORED; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      write_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_STORED; i++) begin
        if (wb_commit && (wb_dest_addr_i == reg_addr_t'(i))) begin
          regs_q[i] <= wb_data_i;
        end else if (base_commit && (base_dest_addr_i == reg_addr_t'(i))) begin
          regs_q[i] <= base_data_i;
        end
      end
      write_count_q <= write_count_q + 32'(wb_commit) + 32'(base_commit);
    end
  end

  assign write_count_o = write_count_q;

  // PC is never stored; its slot reads as zero and the mux substitutes the fetch value.
  function automatic word_t stored_val(input reg_addr_t addr);
    stored_val = '0;
    for (int i = 0; i < NUM_STORED; i++) begin
      if (addr == reg_addr_t'(i)) stored_val = regs_q[i];
    end
  endfunction

  word_t stored_a, stored_b, stored_c;
  assign stored_a = stored_val(rd_addr_a_i);
  assign stored_b = stored_val(rd_addr_b_i);
  assign stored_c = stored_val(rd_addr_c_i);

  reg_read_mux u_mux_a (
    .rst_i(rst_i), .rd_addr_i(rd_addr_a_i), .pc_read_val_i(pc_read_val_i),
    .wb_write_en_i(wb_write_en_i), .wb_dest_addr_i(wb_dest_addr_i), .wb_data_i(wb_data_i),
    .base_write_en_i(base_write_en_i), .base_dest_addr_i(base_dest_addr_i),
    .base_data_i(base_data_i), .stored_i(stored_a), .rd_data_o(rd_data_a_o)
  );

  reg_read_mux u_mux_b (
    .rst_i(rst_i), .rd_addr_i(rd_addr_b_i), .pc_read_val_i(pc_read_val_i),
    .wb_write_en_i(wb_write_en_i), .wb_dest_addr_i(wb_dest_addr_i), .wb_data_i(wb_data_i),
    .base_write_en_i(base_write_en_i), .base_dest_addr_i(base_dest_addr_i),
    .base_data_i(base_data_i), .stored_i(stored_b), .rd_data_o(rd_data_b_o)
  );

  reg_read_mux u_mux_c (
    .rst_i(rst_i), .rd_addr_i(rd_addr_c_i), .pc_read_val_i(pc_read_val_i),
    .wb_write_en_i(wb_write_en_i), .wb_dest_addr_i(wb_dest_addr_i), .wb_data_i(wb_data_i),
    .base_write_en_i(base_write_en_i), .base_dest_addr_i(base_dest_addr_i),
    .base_data_i(base_data_i), .stored_i(stored_c), .rd_data_o(rd_data_c_o)
  );

endmodule

// File: tb/tb_reg_file_bank.sv
// Self-checking bench for reg_file_bank: directed scenarios plus random traffic against an array model.
module tb_reg_file_bank;
  import reg_file_bank_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  reg_file_write_sig wb_write_en_i;
  reg_addr_t         wb_dest_addr_i;
  word_t             wb_data_i;
  reg_file_write_sig base_write_en_i;
  reg_addr_t         base_dest_addr_i;
  word_t             base_data_i;
  word_t             pc_read_val_i;
  reg_addr_t         rd_addr_a_i, rd_addr_b_i, rd_addr_c_i;
  word_t             rd_data_a_o, rd_data_b_o, rd_data_c_o;
  logic [31:0]       write_count_o;

  reg_file_bank dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_write_en_i(wb_write_en_i), .wb_dest_addr_i(wb_dest_addr_i), .wb_data_i(wb_data_i),
    .base_write_en_i(base_write_en_i), .base_dest_addr_i(base_dest_addr_i), .base_data_i(base_data_i),
    .pc_read_val_i(pc_read_val_i),
    .rd_addr_a_i(rd_addr_a_i), .rd_addr_b_i(rd_addr_b_i), .rd_addr_c_i(rd_addr_c_i),
    .rd_data_a_o(rd_data_a_o), .rd_data_b_o(rd_data_b_o), .rd_data_c_o(rd_data_c_o),
    .write_count_o(write_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array of 16 words plus a commit counter.
  logic [31:0] m_regs [16];
  logic [31:0] m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] addr);
    if (addr == 4'd15) return pc_read_val_i;
    if (!rst_i && wb_write_en_i == WRITE_ENABLE && wb_dest_addr_i == addr) return wb_data_i;
    if (!rst_i && base_write_en_i == WRITE_ENABLE && base_dest_addr_i == addr) return base_data_i;
    return m_regs[addr];
  endfunction

  // Apply the architectural rules to the model for the inputs present at the coming edge.
  task automatic m_commit();
    if (rst_i) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_regs[13] = 32'h0000_1000;
      m_count = 32'd0;
    end else begin
      bit wb_ok, base_ok;
      wb_ok   = (wb_write_en_i == WRITE_ENABLE) && (wb_dest_addr_i != 4'd15);
      base_ok = (base_write_en_i == WRITE_ENABLE) && (base_dest_addr_i != 4'd15)
             && !(wb_ok && wb_dest_addr_i == base_dest_addr_i);
      if (base_ok) m_regs[base_dest_addr_i] = base_data_i;
      if (wb_ok)   m_regs[wb_dest_addr_i]   = wb_data_i;
      m_count = m_count + (wb_ok ? 1 : 0) + (base_ok ? 1 : 0);
    end
  endtask

  // Inputs are driven just after the negedge; step commits them and returns at the next negedge.
  task automatic step();
    m_commit();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    wb_write_en_i   = WRITE_DISABLE;
    base_write_en_i = WRITE_DISABLE;
  endtask

  task automatic check_model(input string tag);
    #1;
    check({tag, "_a"}, rd_data_a_o, m_read(rd_addr_a_i));
    check({tag, "_b"}, rd_data_b_o, m_read(rd_addr_b_i));
    check({tag, "_c"}, rd_data_c_o, m_read(rd_addr_c_i));
    check({tag, "_cnt"}, write_count_o, m_count);
  endtask

  task automatic wr(input bit wb_en, input logic [3:0] wa, input logic [31:0] wd,
                    input bit b_en, input logic [3:0] ba, input logic [31:0] bd);
    wb_write_en_i    = wb_en ? WRITE_ENABLE : WRITE_DISABLE;
    wb_dest_addr_i   = wa;
    wb_data_i        = wd;
    base_write_en_i  = b_en ? WRITE_ENABLE : WRITE_DISABLE;
    base_dest_addr_i = ba;
    base_data_i      = bd;
  endtask

  initial begin
    logic [31:0] cnt0;
    foreach (m_regs[i]) m_regs[i] = 32'hx;
    m_count = 32'hx;
    rst_i = 1'b1;
    wr(0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    pc_read_val_i = 32'h0000_0100;
    rd_addr_a_i = 4'd0; rd_addr_b_i = 4'd13; rd_addr_c_i = 4'd14;
    @(negedge clk_i);
    step();
    rst_i = 1'b0;

    // Reset values
    #1;
    check("rst_r0",  rd_data_a_o, 32'd0);
    check("rst_sp",  rd_data_b_o, 32'h0000_1000);
    check("rst_r14", rd_data_c_o, 32'd0);
    check("rst_cnt", write_count_o, 32'd0);

    // Same-cycle bypass, then stored value once the write is gone
    wr(1, 4'd3, 32'hDEAD_BEEF, 0, 4'd0, 32'd0);
    rd_addr_a_i = 4'd3;
    #1 check("bypass_now", rd_data_a_o, 32'hDEAD_BEEF);
    step();
    idle();
    #1 check("bypass_next", rd_data_a_o, 32'hDEAD_BEEF);
    check("bypass_cnt", write_count_o, 32'd1);

    // Collision: wb wins, count +1; then distinct dual write, count +2
    cnt0 = m_count;
    wr(1, 4'd5, 32'd1, 1, 4'd5, 32'd2);
    rd_addr_b_i = 4'd5;
    #1 check("coll_bypass", rd_data_b_o, 32'd1);
    step();
    idle();
    rd_addr_a_i = 4'd5;
    #1 check("coll_r5", rd_data_a_o, 32'd1);
    check("coll_cnt", write_count_o, cnt0 + 32'd1);
    wr(1, 4'd6, 32'd7, 1, 4'd7, 32'd9);
    rd_addr_c_i = 4'd7;
    #1 check("dual_base_bypass", rd_data_c_o, 32'd9);
    step();
    idle();
    rd_addr_a_i = 4'd6; rd_addr_b_i = 4'd7;
    #1 check("dual_r6", rd_data_a_o, 32'd7);
    check("dual_r7", rd_data_b_o, 32'd9);
    check("dual_cnt", write_count_o, cnt0 + 32'd3);

    // PC reads and ignored PC writes
    pc_read_val_i = 32'h0000_0104;
    rd_addr_a_i = 4'd15; rd_addr_b_i = 4'd15; rd_addr_c_i = 4'd15;
    #1 check("pc_a", rd_data_a_o, 32'h0000_0104);
    check("pc_b", rd_data_b_o, 32'h0000_0104);
    check("pc_c", rd_data_c_o, 32'h0000_0104);
    cnt0 = m_count;
    wr(1, 4'd15, 32'hFFFF_FFFF, 1, 4'd15, 32'hFFFF_FFFF);
    #1 check("pc_wr_nobypass", rd_data_a_o, 32'h0000_0104);
    step();
    idle();
    #1 check("pc_wr_cnt", write_count_o, cnt0);
    check("pc_wr_read", rd_data_b_o, 32'h0000_0104);

    // Reset mid-operation: write dropped, no bypass while in reset
    wr(1, 4'd2, 32'h11, 0, 4'd0, 32'd0);
    step();
    wr(1, 4'd2, 32'h55, 1, 4'd4, 32'h66);
    rst_i = 1'b1;
    rd_addr_a_i = 4'd2; rd_addr_b_i = 4'd4;
    #1 check("rst_no_bypass_r2", rd_data_a_o, 32'h11);
    check("rst_no_bypass_r4", rd_data_b_o, 32'd0);
    step();
    rst_i = 1'b0;
    idle();
    #1 check("rst_mid_r2", rd_data_a_o, 32'd0);
    check("rst_mid_r4", rd_data_b_o, 32'd0);
    check("rst_mid_cnt", write_count_o, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_i = ($urandom_range(0, 49) == 0);
      wr($urandom_range(0, 3) != 0, 4'($urandom), $urandom,
         $urandom_range(0, 2) != 0, 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) base_dest_addr_i = wb_dest_addr_i;
      pc_read_val_i = $urandom;
      rd_addr_a_i = 4'($urandom);
      rd_addr_b_i = ($urandom_range(0, 3) == 0) ? wb_dest_addr_i : 4'($urandom);
      rd_addr_c_i = ($urandom_range(0, 3) == 0) ? base_dest_addr_i : 4'($urandom);
      check_model("rand");
      step();
    end
    rst_i = 1'b0;
    idle();
    check_model("rand_end");

    // Counter wrap via backdoor
    force dut.write_count_q = 32'hFFFF_FFFF;
    #1 release dut.write_count_q;
    m_count = 32'hFFFF_FFFF;
    check("wrap_pre", write_count_o, 32'hFFFF_FFFF);
    wr(1, 4'd8, 32'hA5A5_0001, 1, 4'd9, 32'hA5A5_0002);
    step();
    idle();
    #1 check("wrap_cnt", write_count_o, 32'd1);
    check_model("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
